// File: rtl/ok_wire_or_pipe.sv
// Registered wire-OR of N endpoint buses onto one host bus, with a lowest-index
// owner tag, per-cycle collision flag and collision statistics for debug readback.
module ok_wire_or_pipe #(
    parameter int N       = 1,
    parameter int W       = 65,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N*W-1:0]   okEHx,
    input  logic             clr_stats,
    output logic [W-1:0]     okEH,
    output logic [N-1:0]     owner,
    output logic             collision,
    output logic             collision_sticky,
    output logic [15:0]      collision_count,
    output logic [N-1:0]     collision_mask
);

    // Free-running pipeline: one word accepted and one presented every cycle,
    // there is no valid/ready handshake and nothing ever stalls.

    logic [W-1:0] word0;
    logic [N-1:0] act0;
    logic [N-1:0] owner0;
    logic         coll0;

    always_comb begin
        word0 = '0;
        act0  = '0;
        for (int i = 0; i < N; i++) begin
            act0[i] = |okEHx[i*W +: W];
            word0   = word0 | okEHx[i*W +: W];
        end
    end

    // Two's-complement trick isolates the lowest set bit; a & (a-1) is non-zero
    // exactly when two or more bits are set.
    assign owner0 = act0 & (~act0 + N'(1));
    assign coll0  = |(act0 & (act0 - N'(1)));

    logic [LATENCY-1:0][W-1:0] word_q, word_d;
    logic [LATENCY-1:0][N-1:0] own_q, own_d;
    logic [LATENCY-1:0]        coll_q, coll_d;

    always_comb begin
        word_d[0] = word0;
        own_d[0]  = owner0;
        coll_d[0] = coll0;
        for (int s = 1; s < LATENCY; s++) begin
            word_d[s] = word_q[s-1];
            own_d[s]  = own_q[s-1];
            coll_d[s] = coll_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            own_q  <= '0;
            coll_q <= '0;
        end else begin
            word_q <= word_d;
            own_q  <= own_d;
            coll_q <= coll_d;
        end
    end

    assign okEH      = word_q[LATENCY-1];
    assign owner     = own_q[LATENCY-1];
    assign collision = coll_q[LATENCY-1];

    // Activity is only needed up to the stage feeding the statistics, so its
    // pipeline stops one stage short of the output register.
    logic [N-1:0] load_act;
    logic         load_coll;

    assign load_coll = coll_d[LATENCY-1];

    generate
        if (LATENCY == 1) begin : g_act_direct
            assign load_act = act0;
        end else begin : g_act_pipe
            logic [LATENCY-2:0][N-1:0] act_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_q <= '0;
                end else begin
                    act_q[0] <= act0;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        act_q[s] <= act_q[s-1];
                    end
                end
            end
            assign load_act = act_q[LATENCY-2];
        end
    endgenerate

    // A collision arriving on the same edge as a clear is counted after the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_sticky <= 1'b0;
            collision_count  <= '0;
            collision_mask   <= '0;
        end else if (load_coll) begin
            collision_sticky <= 1'b1;
            collision_mask   <= load_act;
            if (clr_stats) begin
                collision_count <= 16'd1;
            end else if (collision_count != 16'hFFFF) begin
                collision_count <= collision_count + 16'd1;
            end
        end else if (clr_stats) begin
            collision_sticky <= 1'b0;
            collision_count  <= '0;
            collision_mask   <= '0;
        end
    end

endmodule

// File: tb/tb_ok_wire_or_pipe.sv
// Bench for ok_wire_or_pipe: three N=4 instances (LATENCY 1, 2, 4) and one N=1
// instance share one stimulus stream; a negedge monitor pops expected words.
module tb_ok_wire_or_pipe;

    localparam int NS = 4;
    localparam int W  = 65;
    localparam int EW = 74;   // {mask[3:0], coll, owner[3:0], word[64:0]}

    logic            clk;
    logic            reset_n;
    logic            clr_stats;
    logic [NS*W-1:0] okehx;

    logic [W-1:0] okeh_o   [3];
    logic [3:0]   owner_o  [3];
    logic         coll_o   [3];
    logic         sticky_o [3];
    logic [15:0]  cnt_o    [3];
    logic [3:0]   mask_o   [3];

    logic [W-1:0] n1_okeh;
    logic         n1_owner;
    logic         n1_coll;
    logic         n1_sticky;
    logic [15:0]  n1_cnt;
    logic         n1_mask;

    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];
    logic [EW-1:0] exp_q4[$];
    logic [W:0]    exp_qn[$];

    int    total = 0;
    int    bad   = 0;
    logic  mon_on = 1'b0;
    logic  clr_s  = 1'b0;
    string lname [3] = '{"L1", "L2", "L4"};

    logic         m_sticky [3];
    logic [15:0]  m_cnt    [3];
    logic [3:0]   m_mask   [3];

    logic [W-1:0] z;
    logic [W-1:0] dtab [4];
    logic [W-1:0] sv   [4];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        ok_wire_or_pipe #(.N(NS), .W(W), .LATENCY(LAT)) u_dut (
            .clk              (clk),
            .reset_n          (reset_n),
            .okEHx            (okehx),
            .clr_stats        (clr_stats),
            .okEH             (okeh_o[g]),
            .owner            (owner_o[g]),
            .collision        (coll_o[g]),
            .collision_sticky (sticky_o[g]),
            .collision_count  (cnt_o[g]),
            .collision_mask   (mask_o[g])
        );
    end

    ok_wire_or_pipe #(.N(1), .W(W), .LATENCY(1)) u_n1 (
        .clk              (clk),
        .reset_n          (reset_n),
        .okEHx            (okehx[W-1:0]),
        .clr_stats        (clr_stats),
        .okEH             (n1_okeh),
        .owner            (n1_owner),
        .collision        (n1_coll),
        .collision_sticky (n1_sticky),
        .collision_count  (n1_cnt),
        .collision_mask   (n1_mask)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) clr_s <= clr_stats;

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            cmp({tag, "_", lname[d], "_okeh"},   okeh_o[d], '0);
            cmp({tag, "_", lname[d], "_owner"},  65'(owner_o[d]), '0);
            cmp({tag, "_", lname[d], "_coll"},   65'(coll_o[d]), '0);
            cmp({tag, "_", lname[d], "_sticky"}, 65'(sticky_o[d]), '0);
            cmp({tag, "_", lname[d], "_cnt"},    65'(cnt_o[d]), '0);
            cmp({tag, "_", lname[d], "_mask"},   65'(mask_o[d]), '0);
        end
        cmp({tag, "_n1_okeh"},  n1_okeh, '0);
        cmp({tag, "_n1_owner"}, 65'(n1_owner), '0);
    endtask

    // scoreboard: expected output plus a statistics model driven by presented words
    task automatic check_dut(input int d, input logic [EW-1:0] e);
        logic [W-1:0] ew;
        logic [3:0]   eo;
        logic         ec;
        logic [3:0]   em;
        ew = e[64:0];
        eo = e[68:65];
        ec = e[69];
        em = e[73:70];
        if (ec) begin
            m_sticky[d] = 1'b1;
            m_mask[d]   = em;
            if (clr_s) m_cnt[d] = 16'd1;
            else if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
        end else if (clr_s) begin
            m_sticky[d] = 1'b0;
            m_cnt[d]    = '0;
            m_mask[d]   = '0;
        end
        cmp({lname[d], "_okeh"},   okeh_o[d], ew);
        cmp({lname[d], "_owner"},  65'(owner_o[d]), 65'(eo));
        cmp({lname[d], "_coll"},   65'(coll_o[d]), 65'(ec));
        cmp({lname[d], "_sticky"}, 65'(sticky_o[d]), 65'(m_sticky[d]));
        cmp({lname[d], "_cnt"},    65'(cnt_o[d]), 65'(m_cnt[d]));
        cmp({lname[d], "_mask"},   65'(mask_o[d]), 65'(m_mask[d]));
    endtask

    // monitor
    always @(negedge clk) begin
        logic [W:0] en;
        if (mon_on) begin
            if (exp_q1.size() >= 1) check_dut(0, exp_q1.pop_front());
            if (exp_q2.size() >= 2) check_dut(1, exp_q2.pop_front());
            if (exp_q4.size() >= 4) check_dut(2, exp_q4.pop_front());
            if (exp_qn.size() >= 1) begin
                en = exp_qn.pop_front();
                cmp("n1_okeh",   n1_okeh, en[W-1:0]);
                cmp("n1_owner",  65'(n1_owner), 65'(en[W]));
                cmp("n1_coll",   65'(n1_coll), '0);
                cmp("n1_sticky", 65'(n1_sticky), '0);
                cmp("n1_cnt",    65'(n1_cnt), '0);
                cmp("n1_mask",   65'(n1_mask), '0);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [W-1:0] s0, input logic [W-1:0] s1,
                         input logic [W-1:0] s2, input logic [W-1:0] s3,
                         input logic clr, input logic [W-1:0] ew,
                         input logic [3:0] eo, input logic ec, input logic [3:0] em);
        okehx     = {s3, s2, s1, s0};
        clr_stats = clr;
        @(posedge clk);
        exp_q1.push_back({em, ec, eo, ew});
        exp_q2.push_back({em, ec, eo, ew});
        exp_q4.push_back({em, ec, eo, ew});
        exp_qn.push_back({|s0, s0});
        #1;
    endtask

    task automatic drive_idle(input logic clr);
        drive(z, z, z, z, clr, z, 4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic drive_coll13();
        drive(z, 65'h3, z, 65'h5, 1'b0, 65'h7, 4'b0010, 1'b1, 4'b1010);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) okehx[i*32 +: 32] = $urandom();
        okehx[259:256] = 4'($urandom_range(15, 0));
    endtask

    // First LATENCY-1 presented words after release are the reset zeros.
    task automatic restart();
        exp_q1.delete();
        exp_q2.delete();
        exp_q4.delete();
        exp_qn.delete();
        exp_q2.push_back('0);
        repeat (3) exp_q4.push_back('0);
        for (int d = 0; d < 3; d++) begin
            m_sticky[d] = 1'b0;
            m_cnt[d]    = '0;
            m_mask[d]   = '0;
        end
        reset_n = 1'b1;
        mon_on  = 1'b1;
    endtask

    task automatic async_reset_mid();
        #2;
        mon_on  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        restart();
    endtask

    initial begin
        z         = '0;
        dtab[0]   = 65'h1_0000_0000_0000_0001;
        dtab[1]   = 65'h0_DEAD_BEEF_0000_0000;
        dtab[2]   = 65'h0_0000_0000_0000_8000;
        dtab[3]   = 65'h1_8000_0000_0000_0000;
        reset_n   = 1'b0;
        clr_stats = 1'b0;
        okehx     = '0;

        repeat (3) begin
            rand_inputs();
            @(posedge clk);
            #1;
            chk_zero("rst");
        end
        okehx = '0;
        restart();
        repeat (3) drive_idle(1'b0);
        chk_zero("release");

        // single source on endpoint 2
        drive(z, z, 65'h1_0000_0000_0000_00A5, z, 1'b0,
              65'h1_0000_0000_0000_00A5, 4'b0100, 1'b0, 4'b0100);
        drive_idle(1'b0);
        cmp("single_okeh",  okeh_o[1], 65'h1_0000_0000_0000_00A5);
        cmp("single_owner", 65'(owner_o[1]), 65'(4'b0100));
        cmp("single_coll",  65'(coll_o[1]), '0);
        cmp("single_cnt",   65'(cnt_o[1]), '0);
        repeat (3) drive_idle(1'b0);

        // collision between endpoints 1 and 3
        drive_coll13();
        drive_idle(1'b0);
        cmp("coll_okeh",   okeh_o[1], 65'h7);
        cmp("coll_owner",  65'(owner_o[1]), 65'(4'b0010));
        cmp("coll_pulse",  65'(coll_o[1]), 65'(1'b1));
        cmp("coll_sticky", 65'(sticky_o[1]), 65'(1'b1));
        cmp("coll_cnt",    65'(cnt_o[1]), 65'(16'd1));
        cmp("coll_mask",   65'(mask_o[1]), 65'(4'b1010));
        drive_idle(1'b0);
        cmp("coll_pulse_end", 65'(coll_o[1]), '0);
        cmp("coll_sticky_hold", 65'(sticky_o[1]), 65'(1'b1));

        // clear racing a collision arriving at the output stage
        drive_idle(1'b1);
        drive_idle(1'b1);
        repeat (7) drive_coll13();
        drive(65'h1, z, 65'h2, z, 1'b0, 65'h3, 4'b0001, 1'b1, 4'b0101);
        cmp("race_pre_cnt", 65'(cnt_o[1]), 65'(16'd7));
        drive_idle(1'b1);
        cmp("race_cnt",    65'(cnt_o[1]), 65'(16'd1));
        cmp("race_sticky", 65'(sticky_o[1]), 65'(1'b1));
        cmp("race_mask",   65'(mask_o[1]), 65'(4'b0101));
        cmp("race_owner",  65'(owner_o[1]), 65'(4'b0001));
        drive_idle(1'b1);
        cmp("clr_cnt",    65'(cnt_o[1]), '0);
        cmp("clr_sticky", 65'(sticky_o[1]), '0);
        cmp("clr_mask",   65'(mask_o[1]), '0);
        repeat (4) drive_idle(1'b0);

        // streaming one-hot sources with an asynchronous reset in the middle
        for (int k = 0; k < 20; k++) begin
            int src;
            int j;
            src = (k * 3) % 4;
            j   = k % 4;
            for (int i = 0; i < 4; i++) sv[i] = '0;
            sv[src] = dtab[j];
            drive(sv[0], sv[1], sv[2], sv[3], 1'b0, dtab[j],
                  4'(1 << src), 1'b0, 4'(1 << src));
            if (k == 9) async_reset_mid();
        end
        repeat (4) drive_idle(1'b0);

        // counter saturation
        repeat (65540) drive_coll13();
        repeat (4) drive_idle(1'b0);
        for (int d = 0; d < 3; d++) begin
            cmp({"sat_", lname[d], "_cnt"},    65'(cnt_o[d]), 65'(16'hFFFF));
            cmp({"sat_", lname[d], "_sticky"}, 65'(sticky_o[d]), 65'(1'b1));
            cmp({"sat_", lname[d], "_mask"},   65'(mask_o[d]), 65'(4'b1010));
        end
        drive_coll13();
        repeat (4) drive_idle(1'b0);
        for (int d = 0; d < 3; d++) begin
            cmp({"sat_hold_", lname[d], "_cnt"}, 65'(cnt_o[d]), 65'(16'hFFFF));
        end

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
